// File: rtl/gps_carr_nco.sv
// Carrier NCO: 32-bit phase accumulator feeding a 4-bit phase index to the sin/cos stage.
// New FCWs are queued in a one-deep slot and applied only at a carrier-cycle boundary.
module gps_carr_nco #(
    parameter int ACC_W = 32,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [ACC_W-1:0] fcw_in,
    input  logic             fcw_valid,
    output logic             fcw_ready,
    input  logic [3:0]       phase_ofs,
    output logic [3:0]       phase,
    output logic             send_en,
    output logic             wrap,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   fcw_active_q, fcw_active_d;
    logic [ACC_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [3:0]         phase_q, phase_d;
    logic               send_en_q, send_en_d;
    logic               wrap_q, wrap_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [ACC_W-1:0]   fcw_eff;
    logic [ACC_W:0]     sum;

    assign fcw_ready = ~pend_valid_q;
    assign phase     = phase_q;
    assign send_en   = send_en_q;
    assign wrap      = wrap_q;
    assign cycle_cnt = cycle_cnt_q;
    assign busy      = (state_q != IDLE);

    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fcw_active_d = fcw_active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        phase_d      = phase_q;
        send_en_d    = send_en_q;
        wrap_d       = wrap_q;
        cycle_cnt_d  = cycle_cnt_q;

        // A queued word takes over on the sample following a wrap sample, keeping phase continuous.
        fcw_eff = (state_q == RUN && wrap_q && pend_valid_q) ? pend_q : fcw_active_q;
        sum     = {1'b0, acc_q} + {1'b0, fcw_eff};

        if (fcw_valid && !pend_valid_q) begin
            pend_d       = fcw_in;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                send_en_d = 1'b0;
                wrap_d    = 1'b0;
                if (pend_valid_q) begin
                    fcw_active_d = pend_q;
                    pend_valid_d = 1'b0;
                end
                if (start) begin
                    state_d     = ARM;
                    acc_d       = '0;
                    cycle_cnt_d = '0;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d   = IDLE;
                    send_en_d = 1'b0;
                    wrap_d    = 1'b0;
                end else begin
                    state_d   = RUN;
                    phase_d   = acc_q[ACC_W-1 -: 4] + phase_ofs;
                    send_en_d = 1'b1;
                    wrap_d    = 1'b0;
                    if (pend_valid_q) begin
                        fcw_active_d = pend_q;
                        pend_valid_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    send_en_d = 1'b0;
                    wrap_d    = 1'b0;
                end else begin
                    acc_d       = sum[ACC_W-1:0];
                    phase_d     = sum[ACC_W-1 -: 4] + phase_ofs;
                    send_en_d   = 1'b1;
                    wrap_d      = sum[ACC_W];
                    cycle_cnt_d = cycle_cnt_q + CYC_W'(sum[ACC_W]);
                    if (wrap_q && pend_valid_q) begin
                        fcw_active_d = pend_q;
                        pend_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                send_en_d = 1'b0;
                wrap_d    = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            fcw_active_q <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            phase_q      <= '0;
            send_en_q    <= 1'b0;
            wrap_q       <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fcw_active_q <= fcw_active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            phase_q      <= phase_d;
            send_en_q    <= send_en_d;
            wrap_q       <= wrap_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

endmodule

// File: tb/tb_gps_carr_nco.sv
// Directed bench for gps_carr_nco; inputs change and outputs are sampled on the falling edge.
// Sample vectors are packed as {send_en, wrap, phase, cycle_cnt}.
module tb_gps_carr_nco;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] fcw_in = '0;
    logic        fcw_valid = 1'b0;
    logic        fcw_ready;
    logic [3:0]  phase_ofs = '0;
    logic [3:0]  phase;
    logic        send_en;
    logic        wrap;
    logic [15:0] cycle_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    gps_carr_nco #(.ACC_W(32), .CYC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .fcw_in    (fcw_in),
        .fcw_valid (fcw_valid),
        .fcw_ready (fcw_ready),
        .phase_ofs (phase_ofs),
        .phase     (phase),
        .send_en   (send_en),
        .wrap      (wrap),
        .cycle_cnt (cycle_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Pulse start; returns during the ARM cycle.
    task automatic do_start(input logic [3:0] ofs);
        @(negedge clk);
        phase_ofs = ofs;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Load a word while idle; it is applied on the following edge.
    task automatic load_idle(input logic [31:0] w);
        @(negedge clk);
        fcw_in    = w;
        fcw_valid = 1'b1;
        @(negedge clk);
        fcw_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] got, exp;
        rst = 1'b0;
        #12;
        got = {phase, send_en, wrap, cycle_cnt, fcw_ready, busy};
        exp = {4'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [21:0] got, exp;
        @(negedge clk);
        fcw_in    = 32'h1000_0000;
        fcw_valid = 1'b1;
        checks++;
        if (fcw_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_idle: got %b expected 1", fcw_ready);
        end
        @(negedge clk);
        fcw_valid = 1'b0;
        checks++;
        if (fcw_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_pending: got %b expected 0", fcw_ready);
        end
        do_start(4'd0);
        checks++;
        if ({busy, fcw_ready} !== 2'b11) begin
            errors++;
            $display("FAIL basic_arm: busy/ready got %b expected 11", {busy, fcw_ready});
        end
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, n == 16, 4'(n), 16'(n >= 16)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_sample%0d: got %h expected %h", n, got, exp);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        got = {send_en, wrap, phase, cycle_cnt};
        exp = {1'b0, 1'b0, 4'd1, 16'd1};
        checks++;
        if (got !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_stop: got %h busy %b expected %h busy 0", got, busy, exp);
        end
    endtask

    task automatic test_offset();
        logic [21:0] got, exp;
        do_start(4'd3);
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, n == 16, 4'(n + 3), 16'(n >= 16)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL offset_sample%0d: got %h expected %h", n, got, exp);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        phase_ofs = 4'd0;
    endtask

    task automatic test_fcw_change();
        logic [21:0] got, exp;
        logic [3:0]  ep;
        logic [15:0] ec;
        logic        er;
        do_start(4'd0);
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            ep  = (n <= 16) ? 4'(n) : 4'((n - 16) * 2);
            ec  = (n >= 24) ? 16'd2 : (n >= 16) ? 16'd1 : 16'd0;
            er  = !(n >= 6 && n <= 16);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, (n == 16 || n == 24), ep, ec};
            checks++;
            if (got !== exp || fcw_ready !== er) begin
                errors++;
                $display("FAIL change_sample%0d: got %h ready %b expected %h ready %b",
                         n, got, fcw_ready, exp, er);
            end
            if (n == 5) begin
                fcw_in    = 32'h2000_0000;
                fcw_valid = 1'b1;
            end
            if (n == 6) fcw_valid = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [21:0] got, exp;
        logic [15:0] ec;
        logic        er;
        int exp_ph [29] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                            0, 2, 4, 6, 8, 10, 12, 14, 0, 4, 8, 12, 0};
        load_idle(32'h1000_0000);
        do_start(4'd0);
        for (int n = 0; n < 29; n++) begin
            @(negedge clk);
            ec  = (n >= 28) ? 16'd3 : (n >= 24) ? 16'd2 : (n >= 16) ? 16'd1 : 16'd0;
            er  = (n <= 2) || (n == 17) || (n >= 25);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, (n == 16 || n == 24 || n == 28), 4'(exp_ph[n]), ec};
            checks++;
            if (got !== exp || fcw_ready !== er) begin
                errors++;
                $display("FAIL b2b_sample%0d: got %h ready %b expected %h ready %b",
                         n, got, fcw_ready, exp, er);
            end
            if (n == 2) begin
                fcw_in    = 32'h2000_0000;
                fcw_valid = 1'b1;
            end
            if (n == 3)  fcw_in = 32'h4000_0000;
            if (n == 18) fcw_valid = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_stop_restart();
        logic [21:0] got, exp;
        load_idle(32'h1000_0000);
        do_start(4'd0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, 1'b0, 4'(n), 16'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop_sample%0d: got %h expected %h", n, got, exp);
            end
        end
        stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stop = 1'b0;
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b0, 1'b0, 4'd9, 16'd0};
            checks++;
            if (got !== exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL stop_hold%0d: got %h busy %b expected %h busy 0", k, got, busy, exp);
            end
        end
        do_start(4'd5);
        checks++;
        if (cycle_cnt !== 16'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_arm: cnt %0d busy %b expected cnt 0 busy 1", cycle_cnt, busy);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, 1'b0, 4'(n + 5), 16'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart_sample%0d: got %h expected %h", n, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [21:0] got, exp;
        logic [23:0] all_got, all_exp;
        @(negedge clk);
        fcw_in    = 32'h3000_0000;
        fcw_valid = 1'b1;
        @(negedge clk);
        fcw_valid = 1'b0;
        checks++;
        if (fcw_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pending: ready got %b expected 0", fcw_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        all_got = {phase, send_en, wrap, cycle_cnt, fcw_ready, busy};
        all_exp = {4'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
        checks++;
        if (all_got !== all_exp) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", all_got, all_exp);
        end
        @(negedge clk);
        rst = 1'b1;
        do_start(4'd6);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            got = {send_en, wrap, phase, cycle_cnt};
            exp = {1'b1, 1'b0, 4'd6, 16'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_const%0d: got %h expected %h", n, got, exp);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset();
        test_fcw_change();
        test_back_to_back();
        test_stop_restart();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gps_carr_nco.md
Name: gps_carr_nco

Overview:
Carrier numerically-controlled oscillator that produces the 4-bit carrier phase index and send enable consumed by the GPS carrier sin/cos lookup stage.
- A 32-bit phase accumulator is advanced once per clock by a frequency control word (FCW).
- The top 4 bits plus a static phase offset form the phase index.
- New FCWs are accepted through a valid/ready handshake and take effect only at a carrier-cycle boundary, so carrier frequency changes are phase-continuous.
- The block counts whole carrier cycles for carrier-phase bookkeeping.

Parameters:
ACC_W, 32, accumulator and FCW width (fixed at 32; FCW = f_carr/f_clk * 2^32)
CYC_W, 16, width of the carrier cycle counter

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
start  input  1  pulse; begin generation (honoured only in IDLE)
stop  input  1  pulse; end generation (honoured only in ARM/RUN)
fcw_in  input  ACC_W  frequency control word
fcw_valid  input  1  fcw_in valid
fcw_ready  output  1  pending-FCW slot empty
phase_ofs  input  4  static phase offset, units of 22.5 deg
phase  output  4  phase index to carrier generator
send_en  output  1  phase holds a valid sample this cycle
wrap  output  1  one-cycle pulse: accumulator carried out on this sample
cycle_cnt  output  CYC_W  completed carrier cycles since start
busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - acc, fcw_active, pending FCW, phase, cycle_cnt = 0.
  - send_en, wrap = 0; pending_valid = 0, so fcw_ready = 1.
- FCW handshake:
  - fcw_ready = ~pending_valid, combinational from a register.
  - A transfer occurs when fcw_valid && fcw_ready on a rising edge: pending <= fcw_in, pending_valid <= 1.
  - fcw_in is ignored while fcw_ready = 0. The source must hold it.
- Pending FCW application:
  - In IDLE, or on the ARM cycle: copied to fcw_active immediately; pending_valid cleared.
  - In RUN: copied only on a cycle where wrap is asserted. The new FCW drives accumulation from the sample after the wrap sample; pending_valid is cleared on that edge.
  - A transfer and an application on the same edge cannot occur, because ready = 0 while pending.
- State machine:
  - IDLE -> ARM on start. On that edge acc <= 0 and cycle_cnt <= 0.
  - ARM -> RUN unconditionally, one cycle. Pending FCW is applied here.
  - RUN stays in RUN until stop.
  - ARM/RUN -> IDLE on stop, with priority over every other event.
  - start is ignored outside IDLE. stop is ignored in IDLE.
- Sample sequence (all outputs registered):
  - Sample n (n = 0, 1, ...) is presented n+1 cycles after the ARM cycle.
  - Accumulator value: A_n = sum of the FCWs active for samples 1..n, mod 2^32. A_0 = 0.
  - phase = (A_n[31:28] + phase_ofs) mod 16.
  - send_en = 1 for every presented sample.
  - phase_ofs is sampled every cycle; a change shifts the next sample only (no accumulator effect).
- wrap: high with sample n (n >= 1) iff A_{n-1} + fcw_active >= 2^32 (carry out of the adder).
- cycle_cnt:
  - Increments, mod 2^CYC_W, on the edge that presents a wrap sample; it is updated together with wrap.
  - Cleared on start.
  - Held in IDLE.
- Stop behaviour:
  - The edge that registers stop drives send_en = 0 and wrap = 0.
  - phase, cycle_cnt and fcw_active hold their last values.
  - A pending FCW stays pending.
- fcw_active = 0: phase stays constant (phase_ofs) and wrap never asserts. This is legal.
- Reset asserted mid-RUN forces all outputs to their reset values immediately; any pending FCW is lost.

Test Plan:
- Reset, then load fcw = 0x1000_0000 while idle; start.
  - Expect fcw_ready back to 1 after ARM.
  - Expect phase 0,1,...,15,0,1 on samples 0..17.
  - Expect wrap and cycle_cnt = 1 only with sample 16.
- Same run with phase_ofs = 3: phase 3,4,...,15,0,1,2,3; wrap still on sample 16 (phase 3).
- While RUN at fcw 0x1000_0000, load fcw 0x2000_0000 at sample 5.
  - fcw_ready stays 0 until the sample-16 wrap cycle.
  - Samples 16,17,18 show phase 0,2,4.
  - Next wrap on sample 24.
- Backpressure: hold fcw_valid high with two different words back-to-back during RUN. The second word is accepted only after the first is applied at a wrap, and no word is dropped or duplicated.
- stop at sample 9, then start 3 cycles later.
  - send_en falls on the edge after stop; phase holds 9 while idle.
  - After restart the phase sequence restarts at phase_ofs and cycle_cnt = 0.
- Assert rst low mid-RUN with a pending FCW: all outputs 0 asynchronously, fcw_ready = 1, state IDLE; start afterwards gives a constant phase (fcw_active = 0).
